// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants and helpers for the inverse ASCON permutation.
//   NR_MAX    maximum number of rounds that can be undone
//   W         state width (five 64-bit lanes, x0 in the top bits)
//   state_e   FSM encoding for round_inv_iter
//   SBOX_INV  inverse 5-bit S-box, index {x0,x1,x2,x3,x4} (x0 = MSB)
//   ROT_A/B   per-lane rotation pair of the forward linear layer
//   rc()      round constant C(i) = ((15-i)<<4) | i
//   lin_step  one factor (I + R^(2^j*a) + R^(2^j*b)) of the inverse linear layer
package ascon_pkg;

  localparam int unsigned NR_MAX = 12;
  localparam int unsigned W      = 320;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIN  = 2'd1,
    ST_SBOX = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Listed from index 31 down to index 0.
  localparam logic [31:0][4:0] SBOX_INV = {
    5'h02, 5'h10, 5'h0c, 5'h0f, 5'h08, 5'h04, 5'h1b, 5'h17,
    5'h1f, 5'h1c, 5'h05, 5'h03, 5'h11, 5'h0b, 5'h16, 5'h18,
    5'h1e, 5'h13, 5'h15, 5'h19, 5'h01, 5'h1d, 5'h06, 5'h0a,
    5'h12, 5'h0e, 5'h09, 5'h00, 5'h0d, 5'h07, 5'h1a, 5'h14
  };

  localparam logic [0:4][5:0] ROT_A = {6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [0:4][5:0] ROT_B = {6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'd15 - i, i};
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] r);
    // Shift by 64 yields zero, so r == 0 degenerates cleanly to x.
    return (x >> r) | (x << (7'd64 - {1'b0, r}));
  endfunction

  // Σ^64 = I over GF(2), so Σ^-1 = Σ^63 = product of these six factors.
  // Rotation amounts wrap mod 64 through the 6-bit truncation of the shift.
  function automatic logic [63:0] lin_step(input logic [63:0] x,
                                           input logic [2:0]  lane,
                                           input logic [2:0]  j);
    logic [5:0] ra;
    logic [5:0] rb;
    ra = ROT_A[lane] << j;
    rb = ROT_B[lane] << j;
    return x ^ rotr64(x, ra) ^ rotr64(x, rb);
  endfunction

endpackage

// File: rtl/sbox_inv.sv
// sbox_inv: combinational 5-bit inverse ASCON S-box.
//   din   5-bit column {x0,x1,x2,x3,x4}, x0 = MSB
//   dout  inverse substitution of din
module sbox_inv
  import ascon_pkg::*;
(
  input  logic [4:0] din,
  output logic [4:0] dout
);

  always_comb dout = SBOX_INV[din];

endmodule

// File: rtl/round_inv_iter.sv
// round_inv_iter: iterative inverse ASCON permutation. Undoes the last
// nrounds rounds of p^12 (round constants C(11) down to C(12-n)).
// Each inverse round: inverse linear layer, inverse S-box, constant removal.
//   clk, rst  clock, asynchronous active-high reset
//   start     request, sampled only in IDLE (with nrounds and s_in)
//   nrounds   rounds to undo, values above 12 clamp to 12
//   busy      high while in LIN or SBOX
//   done      one-cycle pulse, s_out holds the result
//   s_out     working/result state, held until the next accepted start
// Build option ROUND_INV_FAST_LIN_EN: all six linear factors in one LIN
// cycle (2 cycles/round) instead of one factor per cycle (7 cycles/round).
module round_inv_iter
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   nrounds,
  input  logic [W-1:0] s_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s_out
);

  state_e       state_q, state_d;
  logic [3:0]   ridx_q, ridx_d;
  logic [3:0]   rem_q, rem_d;
  logic [W-1:0] s_q, s_d;
`ifndef ROUND_INV_FAST_LIN_EN
  logic [2:0]   step_q, step_d;
`endif

  logic [3:0]   nr_clamped;
  logic [W-1:0] lin_s;
  logic [W-1:0] sb_s;

  assign nr_clamped = (nrounds > 4'(NR_MAX)) ? 4'(NR_MAX) : nrounds;

  // Inverse linear layer; lane x_l occupies bits [(4-l)*64 +: 64].
`ifdef ROUND_INV_FAST_LIN_EN
  always_comb begin
    lin_s = s_q;
    for (int unsigned k = 0; k < 6; k++) begin
      for (int unsigned l = 0; l < 5; l++) begin
        lin_s[(4-l)*64 +: 64] = lin_step(lin_s[(4-l)*64 +: 64], 3'(l), 3'(k));
      end
    end
  end
`else
  always_comb begin
    lin_s = s_q;
    for (int unsigned k = 0; k < 6; k++) begin
      if (step_q == 3'(k)) begin
        for (int unsigned l = 0; l < 5; l++) begin
          lin_s[(4-l)*64 +: 64] = lin_step(s_q[(4-l)*64 +: 64], 3'(l), 3'(k));
        end
      end
    end
  end
`endif

  // Bit-sliced inverse S-box: one lookup per bit column.
  for (genvar i = 0; i < 64; i++) begin : g_sbox
    logic [4:0] col_in;
    logic [4:0] col_out;
    assign col_in = {s_q[256+i], s_q[192+i], s_q[128+i], s_q[64+i], s_q[i]};
    sbox_inv u_sbox_inv (
      .din  (col_in),
      .dout (col_out)
    );
    assign {sb_s[256+i], sb_s[192+i], sb_s[128+i], sb_s[64+i], sb_s[i]} = col_out;
  end

  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    rem_d   = rem_q;
    s_d     = s_q;
`ifndef ROUND_INV_FAST_LIN_EN
    step_d  = step_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = s_in;
          ridx_d  = 4'd11;
          rem_d   = nr_clamped;
`ifndef ROUND_INV_FAST_LIN_EN
          step_d  = '0;
`endif
          state_d = (nr_clamped == 4'd0) ? ST_FIN : ST_LIN;
        end
      end
      ST_LIN: begin
        s_d = lin_s;
`ifdef ROUND_INV_FAST_LIN_EN
        state_d = ST_SBOX;
`else
        if (step_q == 3'd5) begin
          step_d  = '0;
          state_d = ST_SBOX;
        end else begin
          step_d = step_q + 3'd1;
        end
`endif
      end
      ST_SBOX: begin
        s_d            = sb_s;
        s_d[135:128]   = sb_s[135:128] ^ rc(ridx_q);
        rem_d          = rem_q - 4'd1;
        // ridx is left alone on the final round so it never wraps below 0.
        if (rem_q == 4'd1) begin
          state_d = ST_FIN;
        end else begin
          ridx_d  = ridx_q - 4'd1;
          state_d = ST_LIN;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ridx_q  <= '0;
      rem_q   <= '0;
      s_q     <= '0;
`ifndef ROUND_INV_FAST_LIN_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
      rem_q   <= rem_d;
      s_q     <= s_d;
`ifndef ROUND_INV_FAST_LIN_EN
      step_q  <= step_d;
`endif
    end
  end

  assign busy  = (state_q == ST_LIN) || (state_q == ST_SBOX);
  assign done  = (state_q == ST_FIN);
  assign s_out = s_q;

endmodule
